// File: rtl/run_controller_if.sv
// rtl/run_controller_if.sv - control/status bundle between the run controller and its host
//
// Purpose: groups the run/step requests, prescaler setting, CPU status inputs
// and the clock-enable/status outputs of run_controller into one bundle.
// Signals (slave = run_controller view):
//   i_run, i_stop, i_step_cycle, i_step_instr : single-cycle request pulses
//   i_div        [PRESCALE_WIDTH] : one enable every i_div+1 mclk cycles
//   i_instr_end  : CPU on final microstep of an instruction
//   i_hlt_instr  : CPU decoding a HLT opcode
//   i_bp_en, i_bp_addr [ADDR_WIDTH], i_pc [ADDR_WIDTH] : breakpoint compare
//   o_mclk_en    : CPU register clock enable pulse
//   o_halt       : high while HALTED
//   o_state [2]  : HALTED=0, RUN=1, STEP_CYC=2, STEP_INS=3
//   o_bp_hit     : sticky, last halt caused by the breakpoint
interface run_controller_if #(
  parameter int PRESCALE_WIDTH = 16,
  parameter int ADDR_WIDTH     = 4
);
  logic                      i_run;
  logic                      i_stop;
  logic                      i_step_cycle;
  logic                      i_step_instr;
  logic [PRESCALE_WIDTH-1:0] i_div;
  logic                      i_instr_end;
  logic                      i_hlt_instr;
  logic                      i_bp_en;
  logic [ADDR_WIDTH-1:0]     i_bp_addr;
  logic [ADDR_WIDTH-1:0]     i_pc;
  logic                      o_mclk_en;
  logic                      o_halt;
  logic [1:0]                o_state;
  logic                      o_bp_hit;

  modport master (
    output i_run, i_stop, i_step_cycle, i_step_instr, i_div,
           i_instr_end, i_hlt_instr, i_bp_en, i_bp_addr, i_pc,
    input  o_mclk_en, o_halt, o_state, o_bp_hit
  );

  modport slave (
    input  i_run, i_stop, i_step_cycle, i_step_instr, i_div,
           i_instr_end, i_hlt_instr, i_bp_en, i_bp_addr, i_pc,
    output o_mclk_en, o_halt, o_state, o_bp_hit
  );
endinterface

// File: rtl/run_controller.sv
// rtl/run_controller.sv - CPU run/step controller with prescaled clock enable and breakpoint
//
// Purpose: decides whether the CPU runs freely, single-microsteps, steps one
// instruction or stays halted, and emits the prescaled register clock enable.
// Ports:
//   mclk  : system clock, all state updates on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : run_controller_if slave modport (requests, divider, CPU status in;
//           o_mclk_en, o_halt, o_state, o_bp_hit out)
module run_controller #(
  parameter int PRESCALE_WIDTH = 16,
  parameter int ADDR_WIDTH     = 4
) (
  input  logic           mclk,
  input  logic           rst_n,
  run_controller_if.slave bus
);

  typedef enum logic [1:0] {
    HALTED   = 2'd0,
    RUN      = 2'd1,
    STEP_CYC = 2'd2,
    STEP_INS = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic [PRESCALE_WIDTH-1:0] r_cnt;
  logic                      r_bp_hit;
  logic                      w_mclk_en;
  logic                      w_bp_match;
  logic                      w_set_bp;

  // Enable is a pure decode of registered state, so a stop arriving in the
  // same cycle never truncates the pulse already being emitted.
  assign w_mclk_en  = (r_state != HALTED) && (r_cnt == bus.i_div);
  assign w_bp_match = bus.i_instr_end && bus.i_bp_en && (bus.i_pc == bus.i_bp_addr);

  always_comb begin
    w_next_state = r_state;
    w_set_bp     = 1'b0;
    case (r_state)
      HALTED: begin
        if (!bus.i_hlt_instr) begin
          if (bus.i_run)             w_next_state = RUN;
          else if (bus.i_step_instr) w_next_state = STEP_INS;
          else if (bus.i_step_cycle) w_next_state = STEP_CYC;
        end
      end
      default: begin
        if (bus.i_stop || bus.i_hlt_instr) w_next_state = HALTED;
        if (r_state == STEP_CYC && w_mclk_en) w_next_state = HALTED;
        if (r_state == STEP_INS && w_mclk_en && bus.i_instr_end) w_next_state = HALTED;
        if (r_state != STEP_CYC && w_mclk_en && w_bp_match) begin
          w_next_state = HALTED;
          w_set_bp     = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= HALTED;
      r_cnt    <= '0;
      r_bp_hit <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // Held at zero while halted so every restart begins a fresh divide period.
      // A divider lowered below cnt counts on through the natural wrap.
      if (r_state == HALTED)       r_cnt <= '0;
      else if (r_cnt == bus.i_div) r_cnt <= '0;
      else                         r_cnt <= r_cnt + PRESCALE_WIDTH'(1);
      if (r_state == HALTED && w_next_state != HALTED) r_bp_hit <= 1'b0;
      else if (w_set_bp)                                r_bp_hit <= 1'b1;
    end
  end

  assign bus.o_mclk_en = w_mclk_en;
  assign bus.o_halt    = (r_state == HALTED);
  assign bus.o_state   = r_state;
  assign bus.o_bp_hit  = r_bp_hit;

endmodule
